// File: rtl/stream_sorter.sv
// Block sorter: loads N words, runs N odd-even transposition phases, then drains them in order.
// Define SORT_SIGNED_EN to compare words as two's-complement instead of unsigned.
module stream_sorter #(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int DESCEND = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int IW = $clog2(N + 1);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  phase_q, phase_d;
  logic [W-1:0]   mem_q [N];
  logic [W-1:0]   mem_d [N];
  logic [W-1:0]   sort_w [N];
  logic           armed_q;

  function automatic logic greater(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SORT_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic logic need_swap(input logic [W-1:0] lo, input logic [W-1:0] hi);
    if (DESCEND != 0) return greater(hi, lo);
    return greater(lo, hi);
  endfunction

  // One transposition phase: pairs starting at even or odd index, chosen by phase parity.
  always_comb begin
    sort_w = mem_q;
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == phase_q[0]) begin
        if (need_swap(mem_q[i], mem_q[i+1])) begin
          sort_w[i]   = mem_q[i+1];
          sort_w[i+1] = mem_q[i];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    mem_d     = mem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      LOAD: begin
        // The first edge after reset release is not a functional edge, so ready drops until it passes.
        in_ready = armed_q | ~rst_n;
        if (in_valid && armed_q) begin
          mem_d[idx_q[AW-1:0]] = in_data;
          if (idx_q == IW'(N - 1)) begin
            state_d = SORT;
            idx_d   = '0;
            phase_d = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      SORT: begin
        busy  = 1'b1;
        mem_d = sort_w;
        if (phase_q == IW'(N - 1)) begin
          state_d = DRAIN;
          idx_d   = '0;
          phase_d = '0;
        end else begin
          phase_d = phase_q + IW'(1);
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_q[idx_q[AW-1:0]];
        out_last  = (idx_q == IW'(N - 1));
        if (out_ready) begin
          if (idx_q == IW'(N - 1)) begin
            state_d = LOAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      phase_q <= '0;
      armed_q <= 1'b0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      armed_q <= 1'b1;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_stream_sorter.sv
// Directed bench: one ascending and one descending sorter share the same stimulus.
module tb_stream_sorter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       in_ready, out_valid, out_last, busy;
  logic [7:0] out_data;
  logic       in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [7:0] out_data_d;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  stream_sorter #(.W(8), .N(4), .DESCEND(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  stream_sorter #(.W(8), .N(4), .DESCEND(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d), .in_data(in_data),
    .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d), .out_last(out_last_d), .busy(busy_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] din [4];
    logic [7:0] asc [4];
    logic [7:0] dsc [4];
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_d_out_valid"}, out_valid_d, 0);
    chk({tag, "_d_out_data"},  out_data_d,  0);
  endtask

  task automatic load_block(input int vi, input bit chk_ready, output int hs_cyc);
    int k = 0;
    int g = 0;
    hs_cyc = 0;
    while (k < 4 && g < 100) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = tbl[vi].din[k];
      if (chk_ready && g == 0) chk("in_ready_after_last", in_ready, 1);
      if (in_ready) begin
        hs_cyc = cyc;
        k++;
      end
      g++;
    end
    if (k < 4) chk("load_timeout", k, 4);
  endtask

  task automatic drain_block(input int vi, input int rmode, input bit junk, input int hs_cyc);
    int j = 0;
    int g = 0;
    int t = 0;
    bit first = 1'b1;
    bit stalled = 1'b0;
    logic [7:0] pa = 8'h00;
    logic [7:0] pd = 8'h00;
    while (j < 4 && g < 100) begin
      @(negedge clk);
      if (junk) begin
        in_valid = 1'b1;
        in_data  = 8'hAA;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (rmode == 0) ? 1'b1 : (t % 3 == 0);
      if (out_valid) begin
        if (first) begin
          chk("first_out_latency", cyc - hs_cyc, 5);
          chk("busy_drain", busy, 1);
          chk("valid_match", out_valid_d, 1);
          first = 1'b0;
        end
        if (stalled) begin
          chk("hold_asc", out_data, pa);
          chk("hold_dsc", out_data_d, pd);
        end
        chk("out_asc", out_data, tbl[vi].asc[j]);
        chk("out_dsc", out_data_d, tbl[vi].dsc[j]);
        chk("out_last", out_last, (j == 3));
        chk("out_last_d", out_last_d, (j == 3));
        chk("in_ready_drain", in_ready, 0);
        pa = out_data;
        pd = out_data_d;
        stalled = !out_ready;
        t++;
        if (out_ready) j++;
      end else begin
        chk("busy_sort", busy, 1);
        chk("in_ready_sort", in_ready, 0);
      end
      g++;
    end
    if (j < 4) chk("drain_timeout", j, 4);
  endtask

  initial begin
    int hs;
    int hs2;
    tbl[0].din = '{8'd5, 8'd200, 8'd17, 8'd17};
    tbl[0].asc = '{8'd5, 8'd17, 8'd17, 8'd200};
    tbl[0].dsc = '{8'd200, 8'd17, 8'd17, 8'd5};
    tbl[1].din = '{8'd3, 8'd9, 8'd1, 8'd9};
    tbl[1].asc = '{8'd1, 8'd3, 8'd9, 8'd9};
    tbl[1].dsc = '{8'd9, 8'd9, 8'd3, 8'd1};
    tbl[2].din = '{8'h80, 8'h7F, 8'h00, 8'hFF};
`ifdef SORT_SIGNED_EN
    tbl[2].asc = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    tbl[2].dsc = '{8'h7F, 8'h00, 8'hFF, 8'h80};
`else
    tbl[2].asc = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    tbl[2].dsc = '{8'hFF, 8'h80, 8'h7F, 8'h00};
`endif
    tbl[3].din = '{8'd4, 8'd3, 8'd2, 8'd1};
    tbl[3].asc = '{8'd1, 8'd2, 8'd3, 8'd4};
    tbl[3].dsc = '{8'd4, 8'd3, 8'd2, 8'd1};
    tbl[4].din = '{8'd10, 8'd20, 8'd30, 8'd40};
    tbl[4].asc = '{8'd10, 8'd20, 8'd30, 8'd40};
    tbl[4].dsc = '{8'd40, 8'd30, 8'd20, 8'd10};
    tbl[5].din = '{8'd0, 8'd0, 8'd0, 8'd0};
    tbl[5].asc = '{8'd0, 8'd0, 8'd0, 8'd0};
    tbl[5].dsc = '{8'd0, 8'd0, 8'd0, 8'd0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      load_block(i, (i > 0), hs);
      drain_block(i, i % 2, 1'b0, hs);
    end

    // Back-to-back blocks with in_valid and out_ready held high throughout.
    load_block(3, 1'b1, hs);
    drain_block(3, 0, 1'b1, hs);
    load_block(0, 1'b1, hs2);
    chk("b2b_period", hs2 - hs, 12);
    drain_block(0, 0, 1'b1, hs2);

    // Reset in the second SORT cycle discards the partial block.
    load_block(4, 1'b1, hs);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sort1_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_sort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    load_block(3, 1'b0, hs);
    drain_block(3, 1, 1'b0, hs);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stream_sorter.md
STREAM_SORTER -- requirements
Module: stream_sorter

Interface
- REQ-001 Parameter W, default 8: data word width in bits, W >= 1.
- REQ-002 Parameter N, default 4: words per sort block, N >= 2.
- REQ-003 Parameter DESCEND, default 0: 0 emits ascending order, 1 emits descending order.
- REQ-004 clk  input  1: single clock; all state updates on the rising edge.
- REQ-005 rst_n  input  1: asynchronous, active-low reset.
- REQ-006 in_valid  input  1: in_data is valid this cycle.
- REQ-007 in_ready  output  1: block can accept a word this cycle.
- REQ-008 in_data  input  W: input word.
- REQ-009 out_valid  output  1: out_data is valid this cycle.
- REQ-010 out_ready  input  1: consumer accepts out_data this cycle.
- REQ-011 out_data  output  W: sorted output word.
- REQ-012 out_last  output  1: marks the Nth (final) word of a block.
- REQ-013 busy  output  1: high in SORT and DRAIN.

Function
- REQ-014 The block SHALL hold an N-entry buffer, a load/read index and a phase counter, each ceil(log2(N+1)) bits wide.
- REQ-015 The FSM SHALL have three states:
  - LOAD: in_ready=1, out_valid=0.
  - SORT: in_ready=0, out_valid=0.
  - DRAIN: in_ready=0, out_valid=1.
- REQ-016 In LOAD, a handshake (in_valid & in_ready) SHALL write in_data to buf[idx] and increment idx.
- REQ-017 The handshake that writes buf[N-1] SHALL move the FSM to SORT with phase=0.
- REQ-018 In SORT, each cycle SHALL perform one odd-even transposition phase, then increment phase:
  - even phase compares pairs (0,1), (2,3), ...
  - odd phase compares pairs (1,2), (3,4), ...
  - an unpaired end entry is left unchanged.
- REQ-019 A pair (i,i+1) SHALL swap only when buf[i] > buf[i+1] (DESCEND=0) or buf[i] < buf[i+1] (DESCEND=1); equal values never swap.
- REQ-020 After exactly N SORT cycles, the FSM SHALL enter DRAIN with idx=0.
- REQ-021 The first out_valid SHALL appear in the cycle N+1 cycles after the final input handshake.
- REQ-022 In DRAIN:
  - out_data SHALL equal buf[idx].
  - out_last SHALL be 1 only when idx = N-1.
  - out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
- REQ-023 A handshake (out_valid & out_ready) in DRAIN SHALL increment idx.
- REQ-024 The handshake with out_last=1 SHALL return the FSM to LOAD with idx=0, and in_ready SHALL be 1 in the next cycle.
- REQ-025 in_valid outside LOAD SHALL be ignored without side effects.
- REQ-026 Back-to-back blocks SHALL need no idle cycles beyond the SORT window.
- REQ-027 Comparisons SHALL be unsigned W-bit unless the REQ-032 macro is defined; no width extension or truncation of data.
- REQ-028 Throughput SHALL be one block per 2N+N cycles, counting N loads, N sort phases and N drains, under continuous valid/ready.

Reset
- REQ-029 While rst_n=0, the block SHALL asynchronously force:
  - state=LOAD, idx=0, phase=0, all buf entries=0;
  - in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
- REQ-030 Reset asserted mid-LOAD, mid-SORT or mid-DRAIN SHALL discard the partial block; no word from it SHALL ever be emitted.
- REQ-031 Deassertion SHALL take effect at the first rising clk edge after rst_n rises; no handshake SHALL complete on that edge.

Configuration
- REQ-032 With macro SORT_SIGNED_EN defined, all comparisons SHALL treat words as two's-complement signed W-bit values.
- REQ-033 Without SORT_SIGNED_EN, all comparisons SHALL be unsigned; no other behaviour, latency or port SHALL differ between the two builds.

Verification (W=8, N=4, DESCEND=0 unless stated)
- REQ-034 Load 5, 200, 17, 17 -> output 5, 17, 17, 200; out_last only on 200; first out_valid 5 cycles after the last input handshake.
- REQ-035 With DESCEND=1, load 3, 9, 1, 9 -> output 9, 9, 3, 1.
- REQ-036 Drain with out_ready toggling 1,0,0,1,... -> out_data holds while stalled; sequence unchanged; in_ready=0 until the out_last handshake.
- REQ-037 Assert rst_n=0 in the 2nd SORT cycle, then load 4, 3, 2, 1 -> output exactly 1, 2, 3, 4; no words from the first block.
- REQ-038 Load 0x80, 0x7F, 0x00, 0xFF -> unsigned build outputs 0x00, 0x7F, 0x80, 0xFF; SORT_SIGNED_EN build outputs 0x80, 0xFF, 0x00, 0x7F.
- REQ-039 Two blocks with in_valid and out_ready held high -> second block's first input accepted the cycle after the first block's out_last handshake; both blocks sorted correctly.
